// File: rtl/clken_period_meter.sv
// Measures the cycle distance between clock-enable strobes, declares lock after a
// run of in-tolerance periods, and flags/counts rate errors including missing strobes.
module clken_period_meter #(
  parameter int CNT_W      = 16,
  parameter int EXPECTED   = 4,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clk_en,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_valid,
  output logic             o_locked,
  output logic             o_error,
  output logic [7:0]       o_err_count,
  output logic             o_toggle
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  // Lower tolerance bound clamps at zero when TOL exceeds EXPECTED.
  localparam int               TOL_LO_I = (EXPECTED > TOL) ? (EXPECTED - TOL) : 0;
  localparam logic [CNT_W-1:0] TOL_LO   = CNT_W'(TOL_LO_I);
  localparam logic [CNT_W-1:0] TOL_HI   = CNT_W'(EXPECTED + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(EXPECTED + TOL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       LOCK_N   = 8'(LOCK_COUNT);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       match, match_nx, match_inc;
  logic             strobe, in_tol, timeout_hit, err_evt, lock_evt;

  logic [CNT_W-1:0] period_nx;
  logic             valid_nx, locked_nx, error_nx, toggle_nx;
  logic [7:0]       err_count_nx;

  // Event decode shared by next-state and output logic
  always_comb begin
    strobe      = i_clk_en && !i_clear;
    in_tol      = (cnt >= TOL_LO) && (cnt <= TOL_HI);
    match_inc   = match + 8'd1;
    // A strobe landing on the timeout cycle is out of tolerance, so it raises
    // exactly one error through the strobe path rather than two.
    timeout_hit = (state == ST_LOCKED) && !i_clk_en && (cnt == TIMEOUT);
    err_evt     = (state == ST_LOCKED) && ((strobe && !in_tol) || timeout_hit);
    lock_evt    = (state == ST_ACQUIRE) && strobe && in_tol && (match_inc == LOCK_N);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (i_clear) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:    if (strobe)   state_nx = ST_ACQUIRE;
        ST_ACQUIRE: if (lock_evt) state_nx = ST_LOCKED;
        ST_LOCKED:  if (err_evt)  state_nx = ST_ACQUIRE;
        default:                  state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_nx       = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    match_nx     = match;
    period_nx    = o_period;
    valid_nx     = 1'b0;
    locked_nx    = o_locked;
    error_nx     = o_error;
    err_count_nx = o_err_count;
    toggle_nx    = o_toggle;

    if (strobe) begin
      cnt_nx    = CNT_W'(1);
      toggle_nx = ~o_toggle;
      if (state != ST_IDLE) begin
        period_nx = cnt;
        valid_nx  = 1'b1;
      end
    end

    if ((state == ST_ACQUIRE) && strobe) begin
      match_nx = in_tol ? match_inc : 8'd0;
      if (lock_evt) begin
        locked_nx = 1'b1;
        match_nx  = 8'd0;
      end
    end

    if (err_evt) begin
      error_nx     = 1'b1;
      err_count_nx = (o_err_count == 8'hFF) ? o_err_count : o_err_count + 8'd1;
      locked_nx    = 1'b0;
      match_nx     = 8'd0;
    end

    if (i_clear) begin
      cnt_nx       = '0;
      match_nx     = '0;
      period_nx    = '0;
      valid_nx     = 1'b0;
      locked_nx    = 1'b0;
      error_nx     = 1'b0;
      err_count_nx = '0;
      toggle_nx    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt            <= '0;
      match          <= '0;
      o_period       <= '0;
      o_period_valid <= 1'b0;
      o_locked       <= 1'b0;
      o_error        <= 1'b0;
      o_err_count    <= '0;
      o_toggle       <= 1'b0;
    end else begin
      cnt            <= cnt_nx;
      match          <= match_nx;
      o_period       <= period_nx;
      o_period_valid <= valid_nx;
      o_locked       <= locked_nx;
      o_error        <= error_nx;
      o_err_count    <= err_count_nx;
      o_toggle       <= toggle_nx;
    end
  end

endmodule

// File: tb/tb_clken_period_meter.sv
// Scoreboard bench for clken_period_meter: expected period reports are queued at
// stimulus time and matched by a monitor on every o_period_valid pulse.
module tb_clken_period_meter;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_rst_n, i_clk_en, i_clear;
  logic [15:0] o_period;
  logic        o_period_valid, o_locked, o_error, o_toggle;
  logic [7:0]  o_err_count;

  logic        n_clk_en, n_clear;
  logic [3:0]  n_period;
  logic        n_period_valid, n_locked, n_error, n_toggle;
  logic [7:0]  n_err_count;

  clken_period_meter #(.CNT_W(16), .EXPECTED(4), .TOL(0), .LOCK_COUNT(4)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_en(i_clk_en), .i_clear(i_clear),
    .o_period(o_period), .o_period_valid(o_period_valid), .o_locked(o_locked),
    .o_error(o_error), .o_err_count(o_err_count), .o_toggle(o_toggle)
  );

  clken_period_meter #(.CNT_W(4), .EXPECTED(4), .TOL(0), .LOCK_COUNT(4)) u_narrow (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_en(n_clk_en), .i_clear(n_clear),
    .o_period(n_period), .o_period_valid(n_period_valid), .o_locked(n_locked),
    .o_error(n_error), .o_err_count(n_err_count), .o_toggle(n_toggle)
  );

  typedef struct packed {
    logic [15:0] period;
    logic        locked;
    logic        error;
    logic [7:0]  err_count;
    logic        toggle;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_toggle = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Monitor: every period report must match the oldest queued expectation.
  initial begin
    exp_t got, e;
    forever begin
      @(posedge i_clk);
      #1;
      if (o_period_valid === 1'b1) begin
        got = {o_period, o_locked, o_error, o_err_count, o_toggle};
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_report: got period %0d with nothing expected", o_period);
        end else begin
          e = sbq.pop_front();
          chk("period_report", 32'(got), 32'(e));
        end
      end
    end
  end

  task automatic tick(input logic en, input logic clr);
    @(negedge i_clk);
    i_clk_en = en;
    i_clear  = clr;
  endtask

  task automatic first_strobe();
    exp_toggle = ~exp_toggle;
    tick(1'b1, 1'b0);
  endtask

  task automatic strobe_exp(input int gap, input logic lk, input logic er, input int ec);
    exp_t e;
    repeat (gap - 1) tick(1'b0, 1'b0);
    exp_toggle = ~exp_toggle;
    e = '{period: 16'(gap), locked: lk, error: er, err_count: 8'(ec), toggle: exp_toggle};
    sbq.push_back(e);
    tick(1'b1, 1'b0);
  endtask

  task automatic tick_n(input logic en);
    @(negedge i_clk);
    n_clk_en = en;
  endtask

  task automatic check_zero(input string name);
    chk(name, 32'({o_period, o_period_valid, o_locked, o_error, o_err_count, o_toggle}), 32'd0);
  endtask

  initial begin
    int jitter[7];
    jitter = '{4, 4, 5, 4, 4, 4, 4};
    i_rst_n  = 1'b0;
    i_clk_en = 1'b0;
    i_clear  = 1'b0;
    n_clk_en = 1'b0;
    n_clear  = 1'b0;

    #12;
    check_zero("reset_outputs");
    chk("reset_narrow", 32'({n_period, n_period_valid, n_locked, n_error, n_err_count, n_toggle}), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Narrow counter: a 20-cycle gap saturates the 4-bit count at 15
    tick_n(1'b1);
    repeat (19) tick_n(1'b0);
    tick_n(1'b1);
    @(posedge i_clk);
    #1;
    chk("narrow_valid", 32'(n_period_valid), 32'd1);
    chk("narrow_period_sat", 32'(n_period), 32'd15);
    chk("narrow_locked", 32'(n_locked), 32'd0);
    tick_n(1'b0);

    // Lock: 5 strobes every 4 cycles
    first_strobe();
    for (int i = 0; i < 4; i++) strobe_exp(4, (i == 3), 1'b0, 0);

    // Clear coincident with a strobe
    tick(1'b1, 1'b1);
    @(posedge i_clk);
    #1;
    check_zero("clear_outputs");
    exp_toggle = 1'b0;
    tick(1'b0, 1'b0);

    // Jitter during acquire: lock only after the final four 4s
    first_strobe();
    for (int i = 0; i < 7; i++) strobe_exp(jitter[i], (i == 6), 1'b0, 0);

    // Missing strobe: timeout detected 5 cycles after the last strobe
    tick(1'b0, 1'b0);
    repeat (4) @(posedge i_clk);
    #1;
    chk("pre_timeout_state", 32'({o_locked, o_error, o_err_count}), 32'({1'b1, 1'b0, 8'd0}));
    @(posedge i_clk);
    #1;
    chk("timeout_state", 32'({o_locked, o_error, o_err_count}), 32'({1'b0, 1'b1, 8'd1}));

    // Early strobe from a fresh lock, then relock, then a strobe on the timeout cycle
    tick(1'b0, 1'b1);
    exp_toggle = 1'b0;
    tick(1'b0, 1'b0);
    first_strobe();
    for (int i = 0; i < 4; i++) strobe_exp(4, (i == 3), 1'b0, 0);
    strobe_exp(3, 1'b0, 1'b1, 1);
    for (int i = 0; i < 4; i++) strobe_exp(4, (i == 3), 1'b1, 1);
    strobe_exp(5, 1'b0, 1'b1, 2);
    tick(1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    chk("timeout_strobe_single_error", 32'(o_err_count), 32'd2);

    // Asynchronous reset away from any clock edge
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge i_clk);
    i_rst_n    = 1'b1;
    exp_toggle = 1'b0;

    // 300 error events: lock, then one early strobe, repeated
    first_strobe();
    for (int i = 1; i <= 300; i++) begin
      for (int j = 0; j < 4; j++) strobe_exp(4, (j == 3), (i > 1), sat8(i - 1));
      strobe_exp(3, 1'b0, 1'b1, sat8(i));
    end
    tick(1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    chk("err_count_saturated", 32'({o_error, o_err_count}), 32'({1'b1, 8'd255}));

    repeat (3) @(posedge i_clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
